// File: rtl/ext_spike_router.sv
`default_nettype none
// ============================================================================
// Module   : ext_spike_router
// Purpose  : Merges external stimulus spikes with polarity-routed neuron column
//            spikes onto synapse-row inputs; all outputs registered.
//            Optional per-row collision counters: define ROUTER_COLLISION_CNT_EN.
// Revision : 1.0
// ============================================================================
module ext_spike_router #(
    parameter int NUM_SYNAPSE_ROWS = 2,
    parameter int NUM_COLS         = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               route_en,
    input  logic [NUM_SYNAPSE_ROWS-1:0]        ext_valid,
    input  logic [NUM_COLS-1:0]                nn_valid,
    input  logic [NUM_COLS-1:0]                nn_on_off,
    input  logic [NUM_SYNAPSE_ROWS*NUM_COLS-1:0] conn_on,
    input  logic [NUM_SYNAPSE_ROWS*NUM_COLS-1:0] conn_off,
`ifdef ROUTER_COLLISION_CNT_EN
    input  logic                               collision_clr,
    output logic [8*NUM_SYNAPSE_ROWS-1:0]      collision_cnt,
`endif
    output logic [NUM_SYNAPSE_ROWS-1:0]        row_valid,
    output logic [NUM_SYNAPSE_ROWS-1:0]        row_src_ext,
    output logic [NUM_SYNAPSE_ROWS-1:0]        row_src_nn
);

    localparam logic [7:0] C_CNT_MAX = 8'hFF;

    logic [NUM_SYNAPSE_ROWS-1:0] w_nn_hit;
    logic [NUM_SYNAPSE_ROWS-1:0] w_seen;
    logic [NUM_SYNAPSE_ROWS-1:0] w_collide;
    logic                        w_col_hit;

    logic [NUM_SYNAPSE_ROWS-1:0] w_row_valid_d, r_row_valid_q;
    logic [NUM_SYNAPSE_ROWS-1:0] w_row_src_ext_d, r_row_src_ext_q;
    logic [NUM_SYNAPSE_ROWS-1:0] w_row_src_nn_d, r_row_src_nn_q;

    // w_seen tracks "at least one source so far"; a further source on a row
    // that has already seen one marks a collision, avoiding a popcount.
    always_comb begin
        w_nn_hit  = '0;
        w_seen    = ext_valid;
        w_collide = '0;
        w_col_hit = 1'b0;
        for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                w_col_hit = route_en & nn_valid[c] &
                            ((nn_on_off[c] & conn_on[r*NUM_COLS+c]) |
                             (~nn_on_off[c] & conn_off[r*NUM_COLS+c]));
                w_collide[r] = w_collide[r] | (w_seen[r] & w_col_hit);
                w_seen[r]    = w_seen[r] | w_col_hit;
                w_nn_hit[r]  = w_nn_hit[r] | w_col_hit;
            end
        end
    end

    always_comb begin
        w_row_src_ext_d = ext_valid;
        w_row_src_nn_d  = w_nn_hit;
        w_row_valid_d   = ext_valid | w_nn_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_valid_q   <= '0;
            r_row_src_ext_q <= '0;
            r_row_src_nn_q  <= '0;
        end else begin
            r_row_valid_q   <= w_row_valid_d;
            r_row_src_ext_q <= w_row_src_ext_d;
            r_row_src_nn_q  <= w_row_src_nn_d;
        end
    end

    assign row_valid   = r_row_valid_q;
    assign row_src_ext = r_row_src_ext_q;
    assign row_src_nn  = r_row_src_nn_q;

`ifdef ROUTER_COLLISION_CNT_EN
    logic [7:0] w_cnt_d [NUM_SYNAPSE_ROWS];
    logic [7:0] r_cnt_q [NUM_SYNAPSE_ROWS];

    always_comb begin
        for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
            w_cnt_d[r] = r_cnt_q[r];
            if (collision_clr) begin
                w_cnt_d[r] = 8'd0;
            end else if (w_collide[r] && (r_cnt_q[r] != C_CNT_MAX)) begin
                w_cnt_d[r] = r_cnt_q[r] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
            if (reset) begin
                r_cnt_q[r] <= 8'd0;
            end else begin
                r_cnt_q[r] <= w_cnt_d[r];
            end
        end
    end

    for (genvar g = 0; g < NUM_SYNAPSE_ROWS; g++) begin : g_cnt_out
        assign collision_cnt[8*g +: 8] = r_cnt_q[g];
    end
`else
    logic w_unused_collide;
    assign w_unused_collide = ^w_collide;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ext_spike_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_spike_router
// Purpose  : Scoreboard bench for ext_spike_router (optionally with
//            ROUTER_COLLISION_CNT_EN defined).
// Revision : 1.0
// ============================================================================
module tb_ext_spike_router;

    localparam int C_R = 2;
    localparam int C_C = 1;

    typedef struct packed {
        logic [C_R-1:0]   rv;
        logic [C_R-1:0]   se;
        logic [C_R-1:0]   sn;
        logic [8*C_R-1:0] cnt;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               route_en;
    logic [C_R-1:0]     ext_valid;
    logic [C_C-1:0]     nn_valid;
    logic [C_C-1:0]     nn_on_off;
    logic [C_R*C_C-1:0] conn_on;
    logic [C_R*C_C-1:0] conn_off;
    logic               collision_clr;
    logic [8*C_R-1:0]   collision_cnt;
    logic [C_R-1:0]     row_valid;
    logic [C_R-1:0]     row_src_ext;
    logic [C_R-1:0]     row_src_nn;

    exp_t q_exp[$];
    int   m_cnt [C_R];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ext_spike_router #(.NUM_SYNAPSE_ROWS(C_R), .NUM_COLS(C_C)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .route_en     (route_en),
        .ext_valid    (ext_valid),
        .nn_valid     (nn_valid),
        .nn_on_off    (nn_on_off),
        .conn_on      (conn_on),
        .conn_off     (conn_off),
`ifdef ROUTER_COLLISION_CNT_EN
        .collision_clr(collision_clr),
        .collision_cnt(collision_cnt),
`endif
        .row_valid    (row_valid),
        .row_src_ext  (row_src_ext),
        .row_src_nn   (row_src_nn)
    );

`ifndef ROUTER_COLLISION_CNT_EN
    assign collision_cnt = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model for one cycle, then advance and score the DUT output.
    task automatic tick();
        exp_t e;
        int   nsrc;
        logic hit;
        logic ch;
        e = '0;
        for (int r = 0; r < C_R; r++) begin
            hit  = 1'b0;
            nsrc = ext_valid[r] ? 1 : 0;
            for (int c = 0; c < C_C; c++) begin
                ch = route_en && nn_valid[c] &&
                     ((nn_on_off[c] && conn_on[r*C_C+c]) || (!nn_on_off[c] && conn_off[r*C_C+c]));
                if (ch) begin
                    hit  = 1'b1;
                    nsrc = nsrc + 1;
                end
            end
            if (reset || collision_clr) m_cnt[r] = 0;
            else if (nsrc >= 2 && m_cnt[r] < 255) m_cnt[r] = m_cnt[r] + 1;
            if (!reset) begin
                e.rv[r] = ext_valid[r] | hit;
                e.se[r] = ext_valid[r];
                e.sn[r] = hit;
            end
            e.cnt[8*r +: 8] = 8'(m_cnt[r]);
        end
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = q_exp.pop_front();
            chk("row_valid",   32'(row_valid),   32'(e.rv));
            chk("row_src_ext", 32'(row_src_ext), 32'(e.se));
            chk("row_src_nn",  32'(row_src_nn),  32'(e.sn));
`ifdef ROUTER_COLLISION_CNT_EN
            chk("collision_cnt", 32'(collision_cnt), 32'(e.cnt));
`endif
        end
    endtask

    task automatic idle();
        reset = 1'b0; route_en = 1'b0; ext_valid = '0; nn_valid = '0;
        nn_on_off = '0; conn_on = '0; conn_off = '0; collision_clr = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < C_R; r++) m_cnt[r] = 0;
        // Reset with every input asserted
        reset = 1'b1; route_en = 1'b1; ext_valid = '1; nn_valid = '1;
        nn_on_off = '1; conn_on = '1; conn_off = '1; collision_clr = 1'b1;
        repeat (3) tick();
        idle();
        ext_valid = 2'b11;
        tick();
        idle();
        tick();

        // External only
        ext_valid = 2'b01;
        tick();
        idle();
        tick();

        // Polarity routing
        route_en = 1'b1; conn_on = 2'b10; conn_off = 2'b01; nn_valid = 1'b1; nn_on_off = 1'b1;
        tick();
        nn_on_off = 1'b0;
        tick();
        idle();
        tick();

        // Merge ext + on spike on row 1
        route_en = 1'b1; conn_on = 2'b10; nn_valid = 1'b1; nn_on_off = 1'b1; ext_valid = 2'b10;
        tick();
        idle();
        tick();

        // Both polarities enabled on a pair
        route_en = 1'b1; conn_on = 2'b01; conn_off = 2'b01; nn_valid = 1'b1;
        nn_on_off = 1'b1; tick();
        nn_on_off = 1'b0; tick();

        // Blocking: no connection bits, then route_en low
        idle();
        nn_valid = 1'b1; route_en = 1'b1;
        repeat (10) begin nn_on_off = ~nn_on_off; tick(); end
        conn_on = '1; conn_off = '1; route_en = 1'b0;
        repeat (10) begin nn_on_off = ~nn_on_off; tick(); end

        // Reset mid-operation drops the presented spike
        idle();
        route_en = 1'b1; conn_on = '1; nn_valid = 1'b1; nn_on_off = 1'b1; ext_valid = 2'b11;
        tick();
        reset = 1'b1;
        tick();
        idle();
        tick();

        // Continuous input, collisions on row 0 past saturation
        route_en = 1'b1; conn_on = 2'b01; nn_valid = 1'b1; nn_on_off = 1'b1; ext_valid = 2'b01;
        repeat (300) tick();
        collision_clr = 1'b1;
        tick();
        collision_clr = 1'b0;
        repeat (3) tick();
        idle();
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 49) == 0);
            route_en      = ($urandom_range(0, 3) != 0);
            ext_valid     = C_R'($urandom);
            nn_valid      = C_C'($urandom);
            nn_on_off     = C_C'($urandom);
            conn_on       = (C_R*C_C)'($urandom);
            conn_off      = (C_R*C_C)'($urandom);
            collision_clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        idle();
        tick();

        chk("scoreboard_drained", 32'(q_exp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
